// File: rtl/divisor_6bits.sv
// divisor_6bits
//   Sequential signed divider, the inverse of the 6-bit signed multiplier.
//   Restoring division, one quotient bit per clock, MSB first.
//   The operands are converted to magnitudes when the start is accepted.
//   The results are presented in sign-magnitude form:
//   - a quotient magnitude with a sign flag, and
//   - a remainder magnitude with a sign flag (the remainder follows the dividend's sign).
//
// Ports
//   clk   in   system clock, rising edge
//   rst   in   synchronous reset, active-high
//   start in   request, sampled only in IDLE
//   A     in   2W-bit dividend, two's complement
//   B     in   W-bit divisor, two's complement
//   q     out  2W-bit quotient magnitude
//   neg   out  quotient sign (1 = negative)
//   r     out  W-bit remainder magnitude
//   rneg  out  remainder sign
//   busy  out  division in progress
//   done  out  one-cycle pulse when results become valid
//   dbz   out  divide-by-zero flag, valid with done
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; results are held
// CALC  | one restoring step per cycle, 2W steps
// DONE  | results registered, done pulsed, then back to IDLE
module divisor_6bits #(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   q,
  output logic                 neg,
  output logic [WIDTH-1:0]     r,
  output logic                 rneg,
  output logic                 busy,
  output logic                 done,
  output logic                 dbz
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(W2 + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q, state_d;
  // Dividend magnitude; quotient bits shift in from the LSB as dividend bits leave the MSB.
  logic [W2-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  bmag_q, bmag_d;
  logic [WIDTH:0]    pr_q, pr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic              dz_pend_q, dz_pend_d;
  logic [W2-1:0]     q_q, q_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic              neg_q, neg_d, rneg_q, rneg_d;
  logic              busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic [W2-1:0]     a_abs;
  logic [WIDTH-1:0]  b_abs;
  logic [WIDTH:0]    pr_sh;
  logic              qbit;

  // The most negative values negate to themselves.
  // Read as unsigned, that is the correct magnitude.
  assign a_abs = A[W2-1]    ? (~A + 1'b1) : A;
  assign b_abs = B[WIDTH-1] ? (~B + 1'b1) : B;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    bmag_d    = bmag_q;
    pr_d      = pr_q;
    cnt_d     = cnt_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    dz_pend_d = dz_pend_q;
    q_d       = q_q;
    r_d       = r_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    // pr stays below |B| <= 2^(W-1), so dropping its MSB in the shift loses nothing.
    pr_sh     = {pr_q[WIDTH-1:0], acc_q[W2-1]};
    qbit      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          sa_d  = A[W2-1];
          sb_d  = B[WIDTH-1];
          if (B == '0) begin
            dz_pend_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            dz_pend_d = 1'b0;
            acc_d     = a_abs;
            bmag_d    = b_abs;
            pr_d      = '0;
            cnt_d     = CW'(W2);
            busy_d    = 1'b1;
            state_d   = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (pr_sh >= {1'b0, bmag_q}) begin
          pr_d = pr_sh - {1'b0, bmag_q};
          qbit = 1'b1;
        end else begin
          pr_d = pr_sh;
        end
        acc_d = {acc_q[W2-2:0], qbit};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end

      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dz_pend_q) begin
          q_d    = '1;
          r_d    = '0;
          neg_d  = 1'b0;
          rneg_d = 1'b0;
          dbz_d  = 1'b1;
        end else begin
          q_d    = acc_q;
          r_d    = pr_q[WIDTH-1:0];
          neg_d  = (sa_q ^ sb_q) & (acc_q != '0);
          rneg_d = sa_q & (pr_q[WIDTH-1:0] != '0);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      bmag_q    <= '0;
      pr_q      <= '0;
      cnt_q     <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      dz_pend_q <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      bmag_q    <= bmag_d;
      pr_q      <= pr_d;
      cnt_q     <= cnt_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      dz_pend_q <= dz_pend_d;
      q_q       <= q_d;
      r_q       <= r_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign neg  = neg_q;
  assign rneg = rneg_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_divisor_6bits.sv
// tb_divisor_6bits
//   Directed and random division checks for divisor_6bits against an
//   integer-arithmetic reference model.
module tb_divisor_6bits;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [11:0] A;
  logic [5:0]  B;
  logic [11:0] q;
  logic [5:0]  r;
  logic        neg, rneg, busy, done, dbz;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  divisor_6bits #(.WIDTH(6)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .q(q), .neg(neg), .r(r), .rneg(rneg),
    .busy(busy), .done(done), .dbz(dbz)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [11:0] a, input logic [5:0] b);
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    A = 12'($urandom);
    B = 6'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  // The reference model works with integer magnitudes and truncating division.
  task automatic check_res(input string tag, input logic [11:0] a, input logic [5:0] b, input int n);
    int sa, sb, ma, mb, eq, er, elat;
    logic en, ern, edz;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) begin
      eq = 12'hFFF; er = 0; en = 1'b0; ern = 1'b0; edz = 1'b1; elat = 1;
    end else begin
      ma   = (sa < 0) ? -sa : sa;
      mb   = (sb < 0) ? -sb : sb;
      eq   = ma / mb;
      er   = ma % mb;
      en   = ((sa < 0) != (sb < 0)) && (eq != 0);
      ern  = (sa < 0) && (er != 0);
      edz  = 1'b0;
      elat = 13;
    end
    chk($sformatf("%s latency", tag), 32'(n), 32'(elat));
    chk($sformatf("%s done", tag), 32'(done), 32'd1);
    chk($sformatf("%s q", tag), 32'(q), 32'(eq));
    chk($sformatf("%s r", tag), 32'(r), 32'(er));
    chk($sformatf("%s neg", tag), 32'(neg), 32'(en));
    chk($sformatf("%s rneg", tag), 32'(rneg), 32'(ern));
    chk($sformatf("%s dbz", tag), 32'(dbz), 32'(edz));
    chk($sformatf("%s busy_at_done", tag), 32'(busy), 32'd0);
  endtask

  task automatic run(input string tag, input logic [11:0] a, input logic [5:0] b);
    int n;
    logic [11:0] qh;
    launch(a, b);
    if (b != 6'd0) chk($sformatf("%s busy", tag), 32'(busy), 32'd1);
    chk($sformatf("%s dbz_cleared", tag), 32'(dbz), 32'd0);
    wait_done(n);
    check_res(tag, a, b, n);
    qh = q;
    tick();
    chk($sformatf("%s done_pulse", tag), 32'(done), 32'd0);
    chk($sformatf("%s q_hold", tag), 32'(q), 32'(qh));
  endtask

  initial begin
    int n, extra;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    tick(); tick();
    chk("rst q", 32'(q), 32'd0);
    chk("rst r", 32'(r), 32'd0);
    chk("rst flags", 32'({neg, rneg, busy, done, dbz}), 32'd0);
    rst = 1'b0;
    tick();

    run("t1", 12'd63, 6'(-7));
    run("t2a", 12'd200, 6'd5);
    run("t2b", 12'(-100), 6'd7);
    run("t3a", 12'(-2048), 6'd1);
    run("t3b", 12'(-2048), 6'(-32));
    run("t3c", 12'd3, 6'(-7));
    run("t3d", 12'd2047, 6'd31);
    run("t4dbz", 12'd77, 6'd0);
    run("t4next", 12'(-45), 6'd4);

    // A second start mid-division must be ignored.
    launch(12'd63, 6'(-7));
    tick(); tick(); tick();
    A = 12'd5; B = 6'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check_res("t5", 12'd63, 6'(-7), n + 4);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) extra++;
    end
    chk("t5 extra_done", 32'(extra), 32'd0);

    // Reset in the middle of a division aborts it.
    launch(12'(-100), 6'd7);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6 q", 32'(q), 32'd0);
    chk("t6 r", 32'(r), 32'd0);
    chk("t6 flags", 32'({neg, rneg, busy, done, dbz}), 32'd0);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) extra++;
    end
    chk("t6 no_done", 32'(extra), 32'd0);
    run("t6 restart", 12'(-1000), 6'(-13));

    for (int i = 0; i < 40; i++) begin
      logic [11:0] ra;
      logic [5:0]  rb;
      ra = 12'($urandom);
      rb = 6'($urandom);
      if (i % 10 == 9) rb = 6'd0;
      run($sformatf("rnd%0d", i), ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
